// File: rtl/ram_arb_pkg.sv
// Shared opcodes, FSM states and requester id for the two-port RAM access arbiter.
package ram_arb_pkg;

    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam int NUM_PORTS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RCMD,
        S_RWAIT
    } state_t;

    typedef logic req_id_t;

    // First command of every transaction: address opcode depends on direction.
    function automatic logic [1:0] addr_op(input logic we);
        return we ? OP_WADDR : OP_RADDR;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way request picker producing a one-hot winner.
// ARB_ROUND_ROBIN_EN selects round robin (ptr = port holding priority), else port 0 fixed priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
    input  req_id_t    ptr,
`endif
    output logic [1:0] win
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        win = req;
        if (req == 2'b11)
            win = ptr ? 2'b10 : 2'b01;
    end
`else
    // With req[0] low the vector is already either idle or port-1-only.
    assign win = req[0] ? 2'b01 : req;
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the command-driven single-port RAM between two requesters, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to port 0.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_W     = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [DATA_W-1:0]    m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rsp_valid,
    output logic                 m0_rsp_err,
    output logic [DATA_W-1:0]    m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [DATA_W-1:0]    m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rsp_valid,
    output logic                 m1_rsp_err,
    output logic [DATA_W-1:0]    m1_rdata,

    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [DATA_W-1:0]    ram_dout,
    input  logic                 ram_tx_valid,

    output logic                 busy
);

    localparam logic [7:0] TO_CNT = 8'(RD_TIMEOUT);

    typedef struct packed {
        logic                 we;
        logic [ADDR_SIZE-1:0] addr;
        logic [DATA_W-1:0]    wdata;
    } txn_t;

    state_t                       state;
    txn_t                         txn;
    txn_t                         sel;
    req_id_t                      owner;
    req_id_t                      acc_id;
    logic [7:0]                   cnt;
    logic [1:0]                   req_v;
    logic [1:0]                   win;
    logic [1:0]                   gnt_v;
    logic [NUM_PORTS-1:0]         rsp_valid;
    logic [NUM_PORTS-1:0]         rsp_err;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_rdata;

    assign req_v = {m1_req, m0_req};

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t ptr;

    ram_arb_pick u_pick (
        .req (req_v),
        .ptr (ptr),
        .win (win)
    );

    // Priority passes to the port that was not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (|gnt_v)
            ptr <= ~acc_id;
    end
`else
    ram_arb_pick u_pick (
        .req (req_v),
        .win (win)
    );
`endif

    // Grants are masked during reset so the async-clear cycle shows all outputs low.
    assign gnt_v  = (state == S_IDLE && !rst) ? win : 2'b00;
    assign acc_id = gnt_v[1];
    assign busy   = (state != S_IDLE);

    assign m0_gnt       = gnt_v[0];
    assign m1_gnt       = gnt_v[1];
    assign m0_rsp_valid = rsp_valid[0];
    assign m1_rsp_valid = rsp_valid[1];
    assign m0_rsp_err   = rsp_err[0];
    assign m1_rsp_err   = rsp_err[1];
    assign m0_rdata     = rsp_rdata[0];
    assign m1_rdata     = rsp_rdata[1];

    always_comb begin
        sel.we    = acc_id ? m1_we    : m0_we;
        sel.addr  = acc_id ? m1_addr  : m0_addr;
        sel.wdata = acc_id ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            txn          <= '0;
            owner        <= 1'b0;
            cnt          <= '0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            rsp_valid    <= '0;
            rsp_err      <= '0;
            rsp_rdata    <= '0;
        end else begin
            ram_rx_valid <= 1'b0;
            ram_din      <= '0;
            rsp_valid    <= '0;
            rsp_err      <= '0;
            rsp_rdata    <= '0;
            unique case (state)
                S_IDLE: begin
                    if (|gnt_v) begin
                        txn          <= sel;
                        owner        <= acc_id;
                        ram_rx_valid <= 1'b1;
                        ram_din      <= {addr_op(sel.we), sel.addr};
                        state        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    ram_rx_valid <= 1'b1;
                    if (txn.we) begin
                        ram_din <= {OP_WDATA, txn.wdata};
                        state   <= S_DATA;
                    end else begin
                        ram_din <= {OP_READ, {ADDR_SIZE{1'b0}}};
                        state   <= S_RCMD;
                    end
                end
                S_DATA: begin
                    rsp_valid[owner] <= 1'b1;
                    state            <= S_IDLE;
                end
                S_RCMD: begin
                    cnt   <= '0;
                    state <= S_RWAIT;
                end
                S_RWAIT: begin
                    // RWAIT lasts up to RD_TIMEOUT+1 cycles; data on the last one still wins.
                    if (ram_tx_valid) begin
                        rsp_valid[owner] <= 1'b1;
                        rsp_rdata[owner] <= ram_dout;
                        state            <= S_IDLE;
                    end else if (cnt == TO_CNT) begin
                        rsp_valid[owner] <= 1'b1;
                        rsp_err[owner]   <= 1'b1;
                        state            <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized bench: transaction-level model predicts per-cycle RAM commands, grants and responses.
module tb_ram_access_arbiter;

    localparam int T    = 4;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      breq, bwe;
    logic [7:0]      baddr [2];
    logic [7:0]      bwd [2];
    logic [1:0]      gnt, rv, re;
    logic [1:0][7:0] rd;
    logic [9:0]      din;
    logic            rxv, busy, btx;
    logic [7:0]      bdout;

    ram_access_arbiter #(.ADDR_SIZE(8), .DATA_W(8), .RD_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .m0_req(breq[0]), .m0_we(bwe[0]), .m0_addr(baddr[0]), .m0_wdata(bwd[0]),
        .m0_gnt(gnt[0]), .m0_rsp_valid(rv[0]), .m0_rsp_err(re[0]), .m0_rdata(rd[0]),
        .m1_req(breq[1]), .m1_we(bwe[1]), .m1_addr(baddr[1]), .m1_wdata(bwd[1]),
        .m1_gnt(gnt[1]), .m1_rsp_valid(rv[1]), .m1_rsp_err(re[1]), .m1_rdata(rd[1]),
        .ram_din(din), .ram_rx_valid(rxv), .ram_dout(bdout), .ram_tx_valid(btx),
        .busy(busy)
    );

    int n_chk = 0, n_err = 0;
    int t, free_at, prio, rd_fire, cur_delay, force_delay;
    bit rand_en, spur_en, spur_force;
    logic [1:0] drop_pend, last_gnt;
    int exp_rx [MAXC];
    int exp_din [MAXC];
    int exp_rv [2][MAXC];
    int exp_er [2][MAXC];
    int exp_rd [2][MAXC];
    logic [7:0] mdl_mem [256];
    logic [7:0] ram_mem [256];
    logic [7:0] ram_wa, ram_ra;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, t);
        end
    endtask

    task automatic chk_outputs();
        chk("rx_valid", rxv, exp_rx[t]);
        if (exp_rx[t] != 0) chk("ram_din", din, exp_din[t]);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rsp_valid%0d", p), rv[p], exp_rv[p][t]);
            if (exp_rv[p][t] != 0) begin
                chk($sformatf("rsp_err%0d", p), re[p], exp_er[p][t]);
                chk($sformatf("rdata%0d", p), rd[p], exp_rd[p][t]);
            end
        end
    endtask

    // Environment side: requesters drop after a transfer, RAM decodes commands.
    task automatic stim();
        for (int p = 0; p < 2; p++)
            if (drop_pend[p]) begin breq[p] = 1'b0; drop_pend[p] = 1'b0; end
        if (rxv) begin
            case (din[9:8])
                2'b00: ram_wa = din[7:0];
                2'b01: ram_mem[ram_wa] = din[7:0];
                2'b10: ram_ra = din[7:0];
                default: rd_fire = (cur_delay <= T + 2) ? t + 1 + cur_delay : -1;
            endcase
        end
        if (t == rd_fire) begin
            btx = 1'b1;
            bdout = ram_mem[ram_ra];
        end else begin
            btx = (spur_force || (spur_en && $urandom_range(3, 0) == 0)) && (t >= free_at);
            bdout = 8'($urandom);
        end
        for (int p = 0; p < 2; p++)
            if (rand_en && !breq[p] && $urandom_range(2, 0) == 0) begin
                breq[p]  = 1'b1;
                bwe[p]   = 1'($urandom_range(1, 0));
                baddr[p] = 8'($urandom_range(7, 0));
                bwd[p]   = 8'($urandom);
            end
    endtask

    task automatic sched(input int w);
        int a, r, d;
        logic we;
        logic [7:0] ad, wd;
        a = t; we = bwe[w]; ad = baddr[w]; wd = bwd[w];
        exp_rx[a+1]  = 1;
        exp_din[a+1] = (we ? 0 : 2) * 256 + int'(ad);
        exp_rx[a+2]  = 1;
        exp_din[a+2] = we ? 256 + int'(wd) : 3 * 256;
        if (we) begin
            mdl_mem[ad] = wd;
            r = a + 3;
            exp_er[w][r] = 0;
            exp_rd[w][r] = 0;
        end else begin
            if (force_delay >= 0) d = force_delay;
            else d = ($urandom_range(4, 0) == 0) ? 99 : int'($urandom_range(T + 2, 0));
            cur_delay = d;
            if (d <= T) begin
                r = a + 4 + d;
                exp_er[w][r] = 0;
                exp_rd[w][r] = int'(mdl_mem[ad]);
            end else begin
                r = a + 4 + T;
                exp_er[w][r] = 1;
                exp_rd[w][r] = 0;
            end
        end
        exp_rv[w][r] = 1;
        free_at = r;
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        t++;
        chk_outputs();
        stim();
    endtask

    task automatic cyc_end();
        int w;
        logic [1:0] eg;
        #1;
        w = -1;
        eg = 2'b00;
        chk("busy", busy, (t < free_at));
        if (t >= free_at) begin
            if (breq == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = prio;
`else
                w = 0;
`endif
            end else if (breq[0]) w = 0;
            else if (breq[1]) w = 1;
        end
        if (w >= 0) eg[w] = 1'b1;
        last_gnt = gnt;
        chk("gnt", gnt, eg);
        if (w >= 0) begin
            sched(w);
            drop_pend[w] = 1'b1;
            prio = 1 - w;
        end
    endtask

    task automatic cyc();
        cyc_begin();
        cyc_end();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (breq != 2'b00 || t < free_at); i++) cyc();
        chk("drain_req", breq, 2'b00);
    endtask

    task automatic req_one(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        cyc_begin();
        breq[p] = 1'b1; bwe[p] = we; baddr[p] = a; bwd[p] = d;
        cyc_end();
        for (int i = 0; i < 40 && breq[p]; i++) cyc();
        chk("accepted", breq[p], 1'b0);
        for (int i = 0; i < 40 && t < free_at; i++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; breq = '0; bwe = '0; btx = 1'b0; bdout = '0;
        baddr[0] = '0; baddr[1] = '0; bwd[0] = '0; bwd[1] = '0;
        t = 0; free_at = 0; prio = 0; rd_fire = -1; cur_delay = 0; force_delay = -1;
        rand_en = 0; spur_en = 0; spur_force = 0; drop_pend = '0; last_gnt = '0;
        ram_wa = '0; ram_ra = '0;
        for (int i = 0; i < 256; i++) begin mdl_mem[i] = '0; ram_mem[i] = '0; end
        for (int i = 0; i < MAXC; i++) begin
            exp_rx[i] = 0; exp_din[i] = 0;
            for (int p = 0; p < 2; p++) begin exp_rv[p][i] = 0; exp_er[p][i] = 0; exp_rd[p][i] = 0; end
        end

        repeat (2) @(negedge clk);
        breq = 2'b11;
        #1;
        chk("rst0_gnt", gnt, 2'b00);
        chk("rst0_rxv", rxv, 1'b0);
        chk("rst0_din", din, 10'h000);
        chk("rst0_rsp", rv, 2'b00);
        chk("rst0_busy", busy, 1'b0);
        @(negedge clk);
        breq = 2'b00;
        rst = 1'b0;

        // Simultaneous requests twice.
        cyc_begin();
        breq = 2'b11; bwe = 2'b11;
        baddr[0] = 8'h01; bwd[0] = 8'h11; baddr[1] = 8'h02; bwd[1] = 8'h22;
        cyc_end();
        chk("arb1_gnt", last_gnt, 2'b01);
        cyc_begin();
        breq[0] = 1'b1; baddr[0] = 8'h03; bwd[0] = 8'h33;
        cyc_end();
        for (int i = 0; i < 40 && breq == 2'b11; i++) cyc();
`ifdef ARB_ROUND_ROBIN_EN
        chk("arb2_left", breq, 2'b01);
`else
        chk("arb2_left", breq, 2'b10);
`endif
        drain();

        // Write then read-back of 0x3C, then a read whose data never arrives.
        req_one(0, 1'b1, 8'h3C, 8'hA5);
        force_delay = 0;
        req_one(0, 1'b0, 8'h3C, 8'h00);
        chk("rd_3c", rd[0], 8'hA5);
        force_delay = 99;
        req_one(0, 1'b0, 8'h3C, 8'h00);
        chk("to_err", re[0], 1'b1);
        force_delay = -1;

        // Spurious RAM strobes while idle.
        spur_force = 1;
        repeat (6) cyc();
        spur_force = 0;

        // Reset asserted while the write-data command is on the bus.
        cyc_begin();
        breq[0] = 1'b1; bwe[0] = 1'b1; baddr[0] = 8'h20; bwd[0] = 8'h77;
        cyc_end();
        cyc();
        cyc_begin();
        breq[1] = 1'b1; bwe[1] = 1'b1; baddr[1] = 8'h21; bwd[1] = 8'h66;
        rst = 1'b1; btx = 1'b0;
        #1;
        chk("rst_rxv", rxv, 1'b0);
        chk("rst_din", din, 10'h000);
        chk("rst_rsp", rv, 2'b00);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        for (int i = t + 1; i < t + 16; i++) begin
            exp_rx[i] = 0;
            for (int p = 0; p < 2; p++) exp_rv[p][i] = 0;
        end
        free_at = 0; prio = 0; rd_fire = -1; drop_pend = '0;
        @(negedge clk);
        t++;
        rst = 1'b0;
        chk_outputs();
        stim();
        cyc_end();
        chk("post_rst_gnt", last_gnt, 2'b10);
        drain();

        // Random traffic from both ports.
        rand_en = 1; spur_en = 1;
        repeat (600) cyc();
        rand_en = 0;
        drain();
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
